// File: rtl/gf_vme_pkg.sv
// Shared constants and address decode helper for the VME register bank.
package gf_vme_pkg;

  localparam int VME_ADDR_W = 16;
  localparam int VME_DATA_W = 32;

  // 33-bit compare keeps base+n from wrapping past the address space
  function automatic logic in_range(
    input logic [32:0] addr,
    input logic [32:0] base,
    input logic [32:0] n
  );
    return (addr >= base) && (addr < base + n);
  endfunction

endpackage

// File: rtl/gf_vme_strobe_gate.sv
// Turns a level VME strobe into exactly one pulse per access.
module gf_vme_strobe_gate (
  input  logic clk,
  input  logic init_n,
  input  logic strobe,
  input  logic arm,
  output logic take,
  output logic pulse
);

  logic pulse_q, pulse_d;
  logic veto_q, veto_d;

  always_comb begin
    take    = arm & strobe & ~pulse_q & ~veto_q;
    pulse_d = take;
    // veto survives until the strobe has been seen low at an edge
    veto_d  = pulse_q | (veto_q & strobe);
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      pulse_q <= 1'b0;
      veto_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      veto_q  <= veto_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/gf_vme_regbank.sv
// VME slave register bank: RW, read-only status and self-clearing
// command registers behind a tri-state data bus.
module gf_vme_regbank
  import gf_vme_pkg::*;
#(
  parameter int                ADDR_W     = VME_ADDR_W,
  parameter int                DATA_W     = VME_DATA_W,
  parameter int                NREG       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [NREG-1:0]   RO_MASK    = '0,
  parameter logic [NREG-1:0]   PULSE_MASK = '0
) (
  input  logic                   clk,
  input  logic                   init_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   writeRegister,
  input  logic                   readRegister,
  inout  wire  [DATA_W-1:0]      data,
  output logic                   enableReadData,
  output logic [NREG*DATA_W-1:0] q,
  input  logic [NREG*DATA_W-1:0] status_in,
  output logic [NREG-1:0]        wr_stb
);

  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic              take;
  logic              wpulse;

  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [NREG-1:0]   wr_stb_q, wr_stb_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_val;

  assign hit = in_range(33'(address), 33'(BASE_ADDR), 33'(NREG));
  assign idx = address - BASE_ADDR;

  gf_vme_strobe_gate u_wgate (
    .clk    (clk),
    .init_n (init_n),
    .strobe (writeRegister),
    .arm    (hit),
    .take   (take),
    .pulse  (wpulse)
  );

  always_comb begin
    widx_d = take ? idx : widx_q;
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == ADDR_W'(i)) begin
        rd_val = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W]
                            : q[i*DATA_W +: DATA_W];
      end
    end
    en_d = hit & readRegister;
    // sample only on the first edge so the bus stays stable
    rdata_d = (en_d & ~en_q) ? rd_val : rdata_q;
    wr_stb_d = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_stb_d[i] = wpulse & (widx_q == ADDR_W'(i)) & ~RO_MASK[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      widx_q   <= '0;
      wr_stb_q <= '0;
      en_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      widx_q   <= widx_d;
      wr_stb_q <= wr_stb_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign q[i*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      logic [DATA_W-1:0] r_q, r_d;

      always_comb begin
        r_d = PULSE_MASK[i] ? '0 : r_q;
        if (wpulse && (widx_q == ADDR_W'(i))) r_d = data;
      end

      always_ff @(posedge clk) begin
        if (!init_n) r_q <= '0;
        else         r_q <= r_d;
      end

      assign q[i*DATA_W +: DATA_W] = r_q;
    end
  end

  assign enableReadData = en_q;
  assign wr_stb         = wr_stb_q;
  assign data           = en_q ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_gf_vme_regbank.sv
// Scoreboard bench for gf_vme_regbank: directed VME accesses,
// read data and write strobes checked by a separate monitor.
module tb_gf_vme_regbank;

  localparam int          AW   = 16;
  localparam int          DW   = 32;
  localparam int          NR   = 8;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [7:0]  RO   = 8'b0010_0000;
  localparam logic [7:0]  PM   = 8'b0000_0001;

  logic           clk = 1'b0;
  logic           init_n = 1'b0;
  logic           wr = 1'b0;
  logic           rd = 1'b0;
  logic [AW-1:0]  address = '0;
  wire  [DW-1:0]  data;
  logic           en;
  logic [NR*DW-1:0] q;
  logic [NR*DW-1:0] status;
  logic [NR-1:0]  wr_stb;
  logic           tb_drv = 1'b0;
  logic [DW-1:0]  tb_data = '0;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] rd_exp[$];
  int            stb_exp[$];
  bit            mon_on = 1'b0;
  logic          en_prev = 1'b0;

  assign data = (tb_drv && !en) ? tb_data : {DW{1'bz}};

  always #5 clk = ~clk;

  gf_vme_regbank #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NREG       (NR),
    .BASE_ADDR  (BASE),
    .RO_MASK    (RO),
    .PULSE_MASK (PM)
  ) dut (
    .clk            (clk),
    .init_n         (init_n),
    .address        (address),
    .writeRegister  (wr),
    .readRegister   (rd),
    .data           (data),
    .enableReadData (en),
    .q              (q),
    .status_in      (status),
    .wr_stb         (wr_stb)
  );

  function automatic logic [DW-1:0] qreg(input int i);
    return q[i*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input int r, input logic [DW-1:0] d,
                          input int hold, input bit stb);
    address = BASE + AW'(r);
    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = d;
    if (stb) stb_exp.push_back(r);
    step(hold);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(1);
  endtask

  task automatic do_read(input int r, input logic [DW-1:0] exp);
    address = BASE + AW'(r);
    rd = 1'b1;
    rd_exp.push_back(exp);
    step(1);
    chk("rd_latency", DW'(en), 1);
    step(1);
    rd = 1'b0;
    step(1);
    chk("rd_release", DW'(en), 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (en && !en_prev) begin
        if (rd_exp.size() == 0) chk("rd_unexpected", DW'(en), 0);
        else chk("rd_data", data, rd_exp.pop_front());
      end
      en_prev = en;
      if (wr_stb != '0) begin
        if (stb_exp.size() == 0) chk("stb_unexpected", DW'(wr_stb), 0);
        else chk("wr_stb", DW'(wr_stb), DW'(1) << stb_exp.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    status = '0;
    status[5*DW +: DW] = 32'h1234;

    init_n = 1'b0;
    address = BASE + 16'd1;
    wr = 1'b1;
    rd = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'h55;
    step(1);
    chk("rst_q", DW'(q != '0), 0);
    chk("rst_wr_stb", DW'(wr_stb), 0);
    chk("rst_en", DW'(en), 0);

    mon_on = 1'b1;
    init_n = 1'b1;
    rd = 1'b0;
    stb_exp.push_back(1);
    step(2);
    chk("rst_release_q1", qreg(1), 32'h55);
    step(3);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(1);

    address = BASE + 16'd3;
    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'hDEADBEEF;
    stb_exp.push_back(3);
    step(2);
    chk("wr_q3", qreg(3), 32'hDEADBEEF);
    tb_data = 32'h0BADF00D;
    step(8);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(2);
    chk("wr_q3_once", qreg(3), 32'hDEADBEEF);
    chk("keep_q1", qreg(1), 32'h55);
    for (int i = 0; i < NR; i++) begin
      if (i != 1 && i != 3) chk("other_unchanged", qreg(i), 0);
    end

    address = BASE + 16'd4;
    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'h44;
    stb_exp.push_back(4);
    step(1);
    address = BASE + 16'd6;
    step(3);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(1);
    chk("addr_move_q4", qreg(4), 32'h44);
    chk("addr_move_q6", qreg(6), 0);

    do_read(3, 32'hDEADBEEF);

    address = BASE + 16'd8;
    rd = 1'b1;
    step(1);
    chk("miss_hi_en", DW'(en), 0);
    address = BASE - 16'd1;
    step(1);
    chk("miss_lo_en", DW'(en), 0);
    rd = 1'b0;
    step(1);
    do_write(8, 32'h77, 3, 1'b0);

    do_write(5, 32'hFFFF, 3, 1'b0);
    chk("ro_q5", qreg(5), 0);
    do_read(5, 32'h1234);

    address = BASE;
    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'h1;
    stb_exp.push_back(0);
    step(2);
    chk("pulse_q0_set", qreg(0), 32'h1);
    step(1);
    chk("pulse_q0_clr", qreg(0), 0);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(1);

    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'h2;
    stb_exp.push_back(0);
    step(2);
    chk("b2b_first", qreg(0), 32'h2);
    wr = 1'b0;
    step(1);
    wr = 1'b1;
    tb_data = 32'h3;
    stb_exp.push_back(0);
    step(2);
    chk("b2b_second", qreg(0), 32'h3);
    wr = 1'b0;
    tb_drv = 1'b0;
    step(2);
    do_read(0, 32'h0);

    do_write(2, 32'hA, 3, 1'b1);
    address = BASE + 16'd2;
    wr = 1'b1;
    tb_drv = 1'b1;
    tb_data = 32'hB;
    stb_exp.push_back(2);
    step(1);
    rd = 1'b1;
    rd_exp.push_back(32'hA);
    step(1);
    chk("rw_en", DW'(en), 1);
    chk("rw_q2", qreg(2), 32'hB);
    rd = 1'b0;
    wr = 1'b0;
    tb_drv = 1'b0;
    step(3);
    chk("rw_q2_after", qreg(2), 32'hB);

    chk("rd_queue_empty", DW'(rd_exp.size()), 0);
    chk("stb_queue_empty", DW'(stb_exp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
